nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that reuses a single 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first.
- Sits directly upstream of that slice. It sequences operand nibbles into the slice, stores the carry between nibbles, and collects the slice outputs into a full-width result.
- Subtraction is a + ~b + 1: the block inverts b nibble-wise and seeds the carry with 1.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived; number of processing cycles; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- sub  input  1  0 = add, 1 = subtract; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- overflow  output  1  two's-complement overflow

Behaviour:
- One clock domain. rst is asynchronous and active-high. All state and outputs are registered.
- Reset values: state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal nibble index, carry and operand registers = 0.
- States:
  - IDLE: busy=0, done=0. start=1 → latch a, b (b inverted if sub=1), result accumulator cleared, carry ← sub, idx ← 0, go RUN.
  - RUN: busy=1, done=0. On each edge the slice computes nibble idx of a, b(inverted) and carry. The 4-bit slice sum goes to accumulator nibble idx, the slice carry-out goes to the carry register, and idx increments. On the edge with idx = NIBBLES-1: sum ← full accumulator, cout ← final carry, overflow ← carry into MSB XOR carry out of MSB, go DONE.
  - DONE: busy=0, done=1 for exactly this cycle. start=1 → same capture as IDLE, go RUN (back-to-back). start=0 → go IDLE.
- Latency:
  - start sampled at edge E0; nibbles processed at E1..E_NIBBLES.
  - done high in the cycle following E_NIBBLES (4 cycles after E0 for WIDTH=16).
  - Minimum start-to-start spacing is NIBBLES+1 cycles.
- start while busy=1 is ignored. a, b and sub may change freely after capture with no effect.
- sum, cout and overflow change only on the edge entering DONE. They hold between operations, including across a new RUN, until the next DONE. Partial nibbles are never visible on sum.
- Carry propagates across nibble boundaries through the carry register only. Full-width ripple such as 0xFFFF+1 must complete in the same NIBBLES cycles.
- Arithmetic is modulo 2^WIDTH. Carry out of the MSB appears only on cout.
- rst asserted mid-RUN aborts immediately: state IDLE, outputs cleared, no done pulse. After release the block accepts start normally.
- start and rst asserted together: rst wins.

Test Plan (WIDTH=16):
- Add: start, sub=0, a=0x1234, b=0x4321 → busy high 4 cycles, then done 1 cycle, sum=0x5555, cout=0, overflow=0.
- Carry chain: add 0xFFFF+0x0001 → sum=0x0000, cout=1, overflow=0. Separately, add 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtract: sub=1, 0x0005−0x0007 → sum=0xFFFE, cout=0, overflow=0. Separately, 0x8000−0x0001 → sum=0x7FFF, cout=1, overflow=1.
- Protocol: pulse start again and change a/b during RUN → ignored, result matches first operands. Then assert start in the DONE cycle → second operation begins with no IDLE cycle, and its done arrives 5 cycles after the first done.
- Reset mid-operation: assert rst 2 cycles into RUN of 0xFFFF+0x0001 → busy=0 and sum=0 immediately, no done pulse. After release, 0x0001+0x0002 → sum=0x0003 on done.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit add/subtract built around one 4-bit ripple-carry slice.
// One nibble is processed per clock, LSB nibble first, with the carry held in a register.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] base;
    logic             carry;
    logic [WIDTH-1:0] areg, breg, acc, acc_nxt;
    logic [3:0]       na, nb;
    logic [4:0]       slice;
    logic             c3, last, capture;

    // The shared 4-bit slice working on the current nibble
    always_comb begin
        base    = {idx, 2'b00};
        na      = areg[base +: 4];
        nb      = breg[base +: 4];
        slice   = {1'b0, na} + {1'b0, nb} + {4'b0000, carry};
        // carry into bit 3 recovered from the bit-3 sum and its operands
        c3      = na[3] ^ nb[3] ^ slice[3];
        last    = (idx == IDX_W'(NIBBLES - 1));
        acc_nxt = acc;
        acc_nxt[base +: 4] = slice[3:0];
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                capture   = start;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            areg     <= '0;
            breg     <= '0;
            acc      <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (capture) begin
                areg  <= a;
                breg  <= sub ? ~b : b;
                acc   <= '0;
                carry <= sub;
                idx   <= '0;
            end else if (state == S_RUN) begin
                acc   <= acc_nxt;
                carry <= slice[4];
                idx   <= idx + 1'b1;
                // Results are published only as a whole, on entry to DONE
                if (last) begin
                    sum      <= acc_nxt;
                    cout     <= slice[4];
                    overflow <= c3 ^ slice[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed and random operations
// compared against an integer-arithmetic reference model.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, overflow;
    logic [15:0] sum;

    int checks = 0;
    int fails  = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, cout, sum} from signed/unsigned integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        int          sr, ur;
        logic        ov, co;
        logic [15:0] r;
        sr = s ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y));
        ov = (sr > 32767) || (sr < -32768);
        ur = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
        co = s ? (x >= y) : (ur > 65535);
        r  = 16'(ur);
        return {ov, co, r};
    endfunction

    // Launches one operation and waits (bounded) for done; lat counts edges after capture.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         output int lat, output int bcnt);
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y; sub = s;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, cout, overflow} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, cout, overflow}); end
        checks++; if (sum !== 16'h0) begin fails++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [15:0] x, input logic [15:0] y, input logic s);
        int lat, bcnt;
        logic [17:0] exp;
        exp = model(x, y, s);
        do_op(x, y, s, lat, bcnt);
        checks++; if (lat !== 4) begin fails++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
        checks++; if (bcnt !== 4) begin fails++; $display("FAIL %s_busy_cycles got=%0d exp=4", name, bcnt); end
        checks++; if ({overflow, cout, sum} !== exp) begin fails++; $display("FAIL %s_result got ov=%b co=%b sum=%h exp ov=%b co=%b sum=%h", name, overflow, cout, sum, exp[17], exp[16], exp[15:0]); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_in_done got=%b exp=0", name, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
        checks++; if ({overflow, cout, sum} !== exp) begin fails++; $display("FAIL %s_hold got sum=%h exp=%h", name, sum, exp[15:0]); end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [15:0] x, y;
        logic        s;
        logic [17:0] exp;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
            if (i % 8 == 0) y = x;
            exp = model(x, y, s);
            do_op(x, y, s, lat, bcnt);
            checks++; if (lat !== 4 || {overflow, cout, sum} !== exp) begin fails++; $display("FAIL random_%0d a=%h b=%h sub=%b lat=%0d got ov=%b co=%b sum=%h exp ov=%b co=%b sum=%h", i, x, y, s, lat, overflow, cout, sum, exp[17], exp[16], exp[15:0]); end
        end
    endtask

    task automatic test_protocol();
        int lat;
        logic [17:0] exp;
        exp = model(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hF0F0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin fails++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
        checks++; if ({overflow, cout, sum} !== exp) begin fails++; $display("FAIL ignore_start got sum=%h exp=%h", sum, exp[15:0]); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL ignore_no_rerun got busy/done=%b exp=00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, gap;
        logic [17:0] e1, e2;
        e1 = model(16'h8000, 16'h0001, 1'b1);
        e2 = model(16'h0005, 16'h0007, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b1, lat, bcnt);
        checks++; if ({overflow, cout, sum} !== e1) begin fails++; $display("FAIL b2b_first got sum=%h exp=%h", sum, e1[15:0]); end
        start = 1'b1; a = 16'h0005; b = 16'h0007; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'h0; b = 16'h0;
        gap = 1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle got busy=%b exp=1", busy); end
        checks++; if ({overflow, cout, sum} !== e1) begin fails++; $display("FAIL b2b_hold_in_run got sum=%h exp=%h", sum, e1[15:0]); end
        while (!done && gap < 20) begin @(posedge clk); #1; gap++; end
        checks++; if (gap !== 5) begin fails++; $display("FAIL b2b_spacing got=%0d exp=5", gap); end
        checks++; if ({overflow, cout, sum} !== e2) begin fails++; $display("FAIL b2b_second got ov=%b co=%b sum=%h exp ov=%b co=%b sum=%h", overflow, cout, sum, e2[17], e2[16], e2[15:0]); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, seen;
        logic [17:0] exp;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, sum} !== 18'h0) begin fails++; $display("FAIL rst_mid got busy=%b done=%b sum=%h exp 0/0/0000", busy, done, sum); end
        start = 1'b1;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (busy || done) seen++; end
        checks++; if (seen !== 0) begin fails++; $display("FAIL rst_wins_start got active_cycles=%0d exp=0", seen); end
        start = 1'b0; rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (busy || done) seen++; end
        checks++; if (seen !== 0) begin fails++; $display("FAIL rst_no_done got active_cycles=%0d exp=0", seen); end
        exp = model(16'h0001, 16'h0002, 1'b0);
        do_op(16'h0001, 16'h0002, 1'b0, lat, bcnt);
        checks++; if (lat !== 4 || {overflow, cout, sum} !== exp) begin fails++; $display("FAIL rst_recover lat=%0d got sum=%h exp=%h", lat, sum, exp[15:0]); end
    endtask

    initial begin
        test_reset();
        test_directed("add",      16'h1234, 16'h4321, 1'b0);
        test_directed("carry",    16'hFFFF, 16'h0001, 1'b0);
        test_directed("ovf_add",  16'h7FFF, 16'h0001, 1'b0);
        test_directed("sub",      16'h0005, 16'h0007, 1'b1);
        test_directed("ovf_sub",  16'h8000, 16'h0001, 1'b1);
        test_directed("sub_zero", 16'h1234, 16'h0000, 1'b1);
        test_random();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
